clk_recovery: RTL and testbench
===============================

Name: clk_recovery

Overview:
- Receive-side counterpart to the clock generation block. Samples an already-synchronized external clock/data-edge line and detects its edges.
- Measures the half-period in system cycles and locks onto a consistent rate.
- Produces the expected/preemptive rate values and the drift offset that generation consumes (expected_half_rate_minus_two, expected_quarter_rate_minus_one, preemptive_half_rate_minus_one, preemptive_quarter_rate_minus_one, sync_cycle_offset, actual_clk_state).
- Sits between the IO synchronizer and generation.

Parameters:
- LOCK_COUNT, 4: consecutive consistent intervals required to declare lock.
- DRIFT_TOL, 1: max |interval − rate| in cycles still treated as the same rate.
- LOCK_TIMEOUT_EDGES, 32: edges in ACQUIRE without lock before the timeout violation is raised.
- MAX_MULT, 4: largest integer multiple of the rate accepted as like-bits (2..MAX_MULT); fixed at 4 in this revision.

Ports:
- sys_dom_i  input  common_p::clk_dom_s  carries the single system clock and reset. Reset is synchronous and active-low.
- enable_i  input  1  recovery enable; low forces IDLE.
- io_clk_i  input  1  synchronized external line.
- preempt_lead_i  input  clks_alot_p::COUNTER_WIDTH  cycles of preemption subtracted for the preemptive outputs.
- actual_clk_state_o  output  clks_alot_p::clock_state_s  registered level, rising pulse, falling pulse.
- locked_o  output  1  rate outputs valid.
- expected_half_rate_minus_two_o  output  COUNTER_WIDTH
- expected_quarter_rate_minus_one_o  output  COUNTER_WIDTH
- preemptive_half_rate_minus_one_o  output  COUNTER_WIDTH
- preemptive_quarter_rate_minus_one_o  output  COUNTER_WIDTH
- sync_cycle_offset_o  output  COUNTER_WIDTH  signed two's-complement: last interval minus expected interval.
- rate_multiple_o  output  1  one-cycle pulse: interval matched k·R, k in 2..MAX_MULT.
- lost_lock_o  output  1  one-cycle pulse on leaving LOCKED.
- lock_timeout_violation_o  output  1  sticky.

Behaviour:
- Reset (sync, active-low) and enable_i low:
  - state IDLE; every output 0.
  - Internal counter, candidate, match count, attempt count and rate R all 0.
  - The sticky violation clears only here.
- Edge detect:
  - prev register holds last io_clk_i.
  - rise = io & !prev; fall = !io & prev; edge = rise | fall.
  - actual_clk_state_o is registered, so 1-cycle latency from io_clk_i.
- Interval counter:
  - Set to 1 on the cycle edge is detected, else increments, saturating at all-ones.
  - The interval I is the counter value at an edge.
  - I < 2 is always a mismatch.
- States:
  - IDLE: when enable_i is high, go to FIRST_EDGE next cycle.
  - FIRST_EDGE: first edge starts the counter; go to ACQUIRE. No interval is recorded.
  - ACQUIRE, on each edge:
    - If |I − candidate| ≤ DRIFT_TOL and I ≥ 2, match++. Otherwise candidate = I and match = 1.
    - attempt++ saturating.
    - When match reaches LOCK_COUNT: R = candidate, go to LOCKED, locked_o = 1 the following cycle.
    - When attempt reaches LOCK_TIMEOUT_EDGES: set lock_timeout_violation_o and keep acquiring.
  - LOCKED, on each edge:
    - |I − R| ≤ DRIFT_TOL: offset = I − R. R is not updated.
    - Else if |I − k·R| ≤ DRIFT_TOL for smallest k in 2..MAX_MULT: rate_multiple_o pulse, offset = I − k·R.
    - Else: lost_lock_o pulse, locked_o = 0, go to ACQUIRE with candidate = I, match = 1, attempt = 0.
  - LOCKED stall: counter > MAX_MULT·R + DRIFT_TOL with no edge → lost_lock_o pulse, go to FIRST_EDGE.
  - An edge on the same cycle as the stall limit takes priority over the stall.
- Rate outputs:
  - Update on the cycle after entering LOCKED and hold while locked.
  - Hold their last values after lost lock; locked_o qualifies them.
  - expected_half = R − 2.
  - expected_quarter = (R >> 1) − 1.
  - preemptive_half = R − 1 − preempt_lead_i.
  - preemptive_quarter = (R >> 1) − 1 − preempt_lead_i.
  - All subtractions saturate at 0.
- Widths:
  - Multiples are computed at COUNTER_WIDTH+2 bits: 2R by shift, 3R = 2R + R, 4R by shift.
  - Differences are computed signed at COUNTER_WIDTH+3 bits.
  - The offset is truncated to COUNTER_WIDTH after clamping to the signed range.

Decomposition:
- Package clks_alot_p holds COUNTER_WIDTH, clock_state_s (level, rising, falling) and recovery_state_e (IDLE, FIRST_EDGE, ACQUIRE, LOCKED).
- One sub-module, clk_edge_detect: prev register plus registered clock_state_s output. It is reusable by generation's early-edge check.

Test Plan:
- Lock at a steady rate:
  - Stimulus: io toggles every 10 cycles, preempt_lead_i = 2.
  - Required: locked_o rises 1 cycle after the 5th edge is detected. Outputs are 8, 4, 7, 2; offset 0; no pulses.
- Drift within tolerance: locked at R = 10, one interval of 11 then 9 → offsets +1 then −1; R stays 10; locked_o stays 1.
- Like-bits: locked at R = 10, interval 30 → rate_multiple_o pulse, offset 0. Interval 21 → pulse, offset +1.
- Rate change:
  - Locked at R = 10, intervals switch to 16 → lost_lock_o pulse on the first 16.
  - Relock after 3 more 16s.
  - Outputs become 14, 7, 13, 5 with lead 2.
- Stall and timeout:
  - Locked at R = 10, line static → lost_lock_o at counter 42.
  - Then alternating intervals 5/13 for 32 edges → lock_timeout_violation_o set.
  - It stays set until enable_i is low for 1 cycle.
- Sync reset mid-LOCKED: all outputs 0 on the next clock. A glitch interval of 1 in ACQUIRE never counts as a match.

Source files
------------

// File: rtl/clk_recovery_pkg.sv
// Shared types for the clock recovery slice: system clock domain bundle,
// recovered clock state, recovery FSM states and a saturating subtractor.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int COUNTER_WIDTH = 8;

  typedef struct packed {
    logic level;
    logic rising;
    logic falling;
  } clock_state_s;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FIRST_EDGE = 2'd1,
    ACQUIRE    = 2'd2,
    LOCKED     = 2'd3
  } recovery_state_e;

  // a - b, clamped at zero instead of wrapping
  function automatic logic [COUNTER_WIDTH-1:0] sub_sat(
    input logic [COUNTER_WIDTH-1:0] a,
    input logic [COUNTER_WIDTH-1:0] b
  );
    logic [COUNTER_WIDTH:0] t;
    t = {1'b0, a} - {1'b0, b};
    if (t[COUNTER_WIDTH]) begin
      sub_sat = {COUNTER_WIDTH{1'b0}};
    end else begin
      sub_sat = t[COUNTER_WIDTH-1:0];
    end
  endfunction
endpackage

// File: rtl/clk_recovery_edge_detect.sv
// Edge detector for an already-synchronized line: combinational edge flag
// for same-cycle decisions plus a registered level/rise/fall view.
module clk_edge_detect
  import clks_alot_p::*;
(
  input  common_p::clk_dom_s sys_dom_i,
  input  logic               clear_i,
  input  logic               io_clk_i,
  output logic               edge_o,
  output clock_state_s       state_o
);
  logic         clk;
  logic         rst_n;
  logic         prev_q, prev_d;
  logic         rise_s, fall_s;
  clock_state_s state_q, state_d;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  // Compare the line against its previous sample; clear forces a quiet state
  always_comb begin
    rise_s = io_clk_i & ~prev_q;
    fall_s = ~io_clk_i & prev_q;
    edge_o = rise_s | fall_s;
    if (clear_i) begin
      prev_d  = 1'b0;
      state_d = 3'b000;
    end else begin
      prev_d  = io_clk_i;
      state_d = {io_clk_i, rise_s, fall_s};
    end
  end

  // Previous-sample and registered clock-state flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      state_q <= 3'b000;
    end else begin
      prev_q  <= prev_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/clk_recovery.sv
// Receive-side clock recovery: measures the half-period of the synchronized
// line, locks onto a steady rate and publishes rate/offset values for generation.
module clk_recovery
  import clks_alot_p::*;
#(
  parameter int LOCK_COUNT         = 4,
  parameter int DRIFT_TOL          = 1,
  parameter int LOCK_TIMEOUT_EDGES = 32,
  parameter int MAX_MULT           = 4
) (
  input  common_p::clk_dom_s       sys_dom_i,
  input  logic                     enable_i,
  input  logic                     io_clk_i,
  input  logic [COUNTER_WIDTH-1:0] preempt_lead_i,
  output clock_state_s             actual_clk_state_o,
  output logic                     locked_o,
  output logic [COUNTER_WIDTH-1:0] expected_half_rate_minus_two_o,
  output logic [COUNTER_WIDTH-1:0] expected_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] preemptive_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] preemptive_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] sync_cycle_offset_o,
  output logic                     rate_multiple_o,
  output logic                     lost_lock_o,
  output logic                     lock_timeout_violation_o
);
  localparam int CW = COUNTER_WIDTH;
  localparam int MW = CW + 2;   // multiples of the rate
  localparam int DW = CW + 3;   // signed differences
  localparam int OFS_MAX_I = (1 << (CW - 1)) - 1;
  localparam int OFS_MIN_I = -(1 << (CW - 1));
  localparam logic signed [DW-1:0] TOL_S   = DW'(DRIFT_TOL);
  localparam logic signed [DW-1:0] OFS_MAX = DW'(OFS_MAX_I);
  localparam logic signed [DW-1:0] OFS_MIN = DW'(OFS_MIN_I);
  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_COUNT);
  localparam logic [5:0] TIMEOUT_C  = 6'(LOCK_TIMEOUT_EDGES);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ALL1_C  = {CW{1'b1}};

  function automatic logic within_tol(input logic signed [DW-1:0] d);
    within_tol = (d <= TOL_S) && (d >= -TOL_S);
  endfunction

  // Clamp to the signed COUNTER_WIDTH range before truncating
  function automatic logic [CW-1:0] clamp_ofs(input logic signed [DW-1:0] d);
    if (d > OFS_MAX) begin
      clamp_ofs = OFS_MAX[CW-1:0];
    end else if (d < OFS_MIN) begin
      clamp_ofs = OFS_MIN[CW-1:0];
    end else begin
      clamp_ofs = d[CW-1:0];
    end
  endfunction

  logic            clk, rst_n, edge_s, clear_s;
  recovery_state_e state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d, cand_q, cand_d, rate_q, rate_d;
  logic [3:0]      match_q, match_d;
  logic [5:0]      attempt_q, attempt_d;
  logic [CW-1:0]   offset_q, offset_d, quarter_s;
  logic [CW-1:0]   exp_half_q, exp_half_d, exp_quarter_q, exp_quarter_d;
  logic [CW-1:0]   pre_half_q, pre_half_d, pre_quarter_q, pre_quarter_d;
  logic            locked_q, locked_d, mult_q, mult_d, lost_q, lost_d, viol_q, viol_d;
  logic [MW-1:0]   r1_s, r2_s, r3_s, r4_s;
  logic signed [DW-1:0] i_s, d_cand_s, d1_s, d2_s, d3_s, d4_s;
  logic            acq_match_s, stall_s;

  assign clk     = sys_dom_i.clk;
  assign rst_n   = sys_dom_i.rst_n;
  assign clear_s = ~enable_i;

  clk_edge_detect u_edge (
    .sys_dom_i (sys_dom_i),
    .clear_i   (clear_s),
    .io_clk_i  (io_clk_i),
    .edge_o    (edge_s),
    .state_o   (actual_clk_state_o)
  );

  // Rate multiples and signed distances of the current interval to each target
  always_comb begin
    r1_s        = {2'b00, rate_q};
    r2_s        = {1'b0, rate_q, 1'b0};
    r3_s        = r2_s + r1_s;
    r4_s        = {rate_q, 2'b00};
    i_s         = $signed({3'b000, counter_q});
    d_cand_s    = i_s - $signed({3'b000, cand_q});
    d1_s        = i_s - $signed({1'b0, r1_s});
    d2_s        = i_s - $signed({1'b0, r2_s});
    d3_s        = i_s - $signed({1'b0, r3_s});
    d4_s        = i_s - $signed({1'b0, r4_s});
    acq_match_s = (counter_q >= CW'(2)) && within_tol(d_cand_s);
    stall_s     = i_s > ($signed({1'b0, r4_s}) + TOL_S);
  end

  // Interval counter and recovery FSM: acquire, lock, track drift, detect loss
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    cand_d    = cand_q;
    match_d   = match_q;
    attempt_d = attempt_q;
    rate_d    = rate_q;
    offset_d  = offset_q;
    mult_d    = 1'b0;
    lost_d    = 1'b0;
    viol_d    = viol_q;
    if (!enable_i) begin
      state_d   = IDLE;
      counter_d = ZERO_C;
      cand_d    = ZERO_C;
      match_d   = 4'd0;
      attempt_d = 6'd0;
      rate_d    = ZERO_C;
      offset_d  = ZERO_C;
      viol_d    = 1'b0;
    end else begin
      if (state_q == IDLE) begin
        counter_d = ZERO_C;
      end else if (edge_s) begin
        counter_d = CW'(1);
      end else if (counter_q != ALL1_C) begin
        counter_d = counter_q + CW'(1);
      end else begin
        counter_d = counter_q;
      end
      case (state_q)
        IDLE: state_d = FIRST_EDGE;
        FIRST_EDGE: begin
          if (edge_s) state_d = ACQUIRE;
          else        state_d = FIRST_EDGE;
        end
        ACQUIRE: begin
          if (edge_s) begin
            if (acq_match_s) begin
              match_d = match_q + 4'd1;
            end else begin
              cand_d  = counter_q;
              match_d = 4'd1;
            end
            if (attempt_q != 6'h3F) attempt_d = attempt_q + 6'd1;
            else                    attempt_d = attempt_q;
            if (match_d >= LOCK_CNT_C) begin
              rate_d  = cand_d;
              state_d = LOCKED;
            end else begin
              state_d = ACQUIRE;
            end
            if (attempt_d >= TIMEOUT_C) viol_d = 1'b1;
            else                        viol_d = viol_q;
          end else begin
            state_d = ACQUIRE;
          end
        end
        LOCKED: begin
          if (edge_s) begin
            if (within_tol(d1_s)) begin
              offset_d = clamp_ofs(d1_s);
            end else if (within_tol(d2_s)) begin
              mult_d   = 1'b1;
              offset_d = clamp_ofs(d2_s);
            end else if ((MAX_MULT >= 3) && within_tol(d3_s)) begin
              mult_d   = 1'b1;
              offset_d = clamp_ofs(d3_s);
            end else if ((MAX_MULT >= 4) && within_tol(d4_s)) begin
              mult_d   = 1'b1;
              offset_d = clamp_ofs(d4_s);
            end else begin
              lost_d    = 1'b1;
              state_d   = ACQUIRE;
              cand_d    = counter_q;
              match_d   = 4'd1;
              attempt_d = 6'd0;
            end
          end else if (stall_s) begin
            // line went quiet for longer than any accepted multiple
            lost_d    = 1'b1;
            state_d   = FIRST_EDGE;
            cand_d    = ZERO_C;
            match_d   = 4'd0;
            attempt_d = 6'd0;
          end else begin
            state_d = LOCKED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Rate outputs follow R while locked and hold their last values otherwise
  always_comb begin
    quarter_s = sub_sat({1'b0, rate_q[CW-1:1]}, CW'(1));
    if (!enable_i) begin
      exp_half_d    = ZERO_C;
      exp_quarter_d = ZERO_C;
      pre_half_d    = ZERO_C;
      pre_quarter_d = ZERO_C;
      locked_d      = 1'b0;
    end else if (state_q == LOCKED) begin
      exp_half_d    = sub_sat(rate_q, CW'(2));
      exp_quarter_d = quarter_s;
      pre_half_d    = sub_sat(sub_sat(rate_q, CW'(1)), preempt_lead_i);
      pre_quarter_d = sub_sat(quarter_s, preempt_lead_i);
      locked_d      = (state_d == LOCKED);
    end else begin
      exp_half_d    = exp_half_q;
      exp_quarter_d = exp_quarter_q;
      pre_half_d    = pre_half_q;
      pre_quarter_d = pre_quarter_q;
      locked_d      = 1'b0;
    end
  end

  // State, measurement and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      counter_q     <= ZERO_C;
      cand_q        <= ZERO_C;
      match_q       <= 4'd0;
      attempt_q     <= 6'd0;
      rate_q        <= ZERO_C;
      offset_q      <= ZERO_C;
      exp_half_q    <= ZERO_C;
      exp_quarter_q <= ZERO_C;
      pre_half_q    <= ZERO_C;
      pre_quarter_q <= ZERO_C;
      locked_q      <= 1'b0;
      mult_q        <= 1'b0;
      lost_q        <= 1'b0;
      viol_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      cand_q        <= cand_d;
      match_q       <= match_d;
      attempt_q     <= attempt_d;
      rate_q        <= rate_d;
      offset_q      <= offset_d;
      exp_half_q    <= exp_half_d;
      exp_quarter_q <= exp_quarter_d;
      pre_half_q    <= pre_half_d;
      pre_quarter_q <= pre_quarter_d;
      locked_q      <= locked_d;
      mult_q        <= mult_d;
      lost_q        <= lost_d;
      viol_q        <= viol_d;
    end
  end

  assign locked_o                            = locked_q;
  assign expected_half_rate_minus_two_o      = exp_half_q;
  assign expected_quarter_rate_minus_one_o   = exp_quarter_q;
  assign preemptive_half_rate_minus_one_o    = pre_half_q;
  assign preemptive_quarter_rate_minus_one_o = pre_quarter_q;
  assign sync_cycle_offset_o                 = offset_q;
  assign rate_multiple_o                     = mult_q;
  assign lost_lock_o                         = lost_q;
  assign lock_timeout_violation_o            = viol_q;
endmodule

// File: tb/tb_clk_recovery.sv
// Directed bench for clk_recovery: per-edge expectations are queued when an
// edge is driven and checked on the cycle the registered result appears.
module tb_clk_recovery;
  import clks_alot_p::*;
  localparam int CW = COUNTER_WIDTH;

  typedef struct {
    int            cyc;
    logic          m;
    logic          l;
    logic          co;
    logic [CW-1:0] o;
  } exp_t;

  logic clk, rst_n, enable, io;
  logic [CW-1:0] lead;
  common_p::clk_dom_s sys_dom;
  clock_state_s clk_state;
  logic locked, mult, lost, viol;
  logic [CW-1:0] eh, eq, ph, pq, ofs;

  exp_t sb[$];
  int cyc, last_t, vectors, miscompares;

  assign sys_dom = {clk, rst_n};

  clk_recovery dut (
    .sys_dom_i                           (sys_dom),
    .enable_i                            (enable),
    .io_clk_i                            (io),
    .preempt_lead_i                      (lead),
    .actual_clk_state_o                  (clk_state),
    .locked_o                            (locked),
    .expected_half_rate_minus_two_o      (eh),
    .expected_quarter_rate_minus_one_o   (eq),
    .preemptive_half_rate_minus_one_o    (ph),
    .preemptive_quarter_rate_minus_one_o (pq),
    .sync_cycle_offset_o                 (ofs),
    .rate_multiple_o                     (mult),
    .lost_lock_o                         (lost),
    .lock_timeout_violation_o            (viol)
  );

  // free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge; pop a due expectation or require quiet pulses
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("edge_mult", 32'(mult), 32'(e.m));
      chk("edge_lost", 32'(lost), 32'(e.l));
      if (e.l) chk("lost_unlocked", 32'(locked), 32'd0);
      if (e.co) chk("edge_offset", 32'(ofs), 32'(e.o));
    end else begin
      chk("quiet_mult", 32'(mult), 32'd0);
      chk("quiet_lost", 32'(lost), 32'd0);
    end
  endtask

  // toggle the line n cycles after the previous toggle
  task automatic edge_at(input int n);
    while (cyc < last_t + n) step();
    io = ~io;
    last_t = cyc;
  endtask

  task automatic expect_ev(input int when, input logic m, input logic l,
                           input logic co, input logic [CW-1:0] o);
    exp_t e;
    e = '{when, m, l, co, o};
    sb.push_back(e);
  endtask

  task automatic chk_rates(input logic [CW-1:0] h, input logic [CW-1:0] q,
                           input logic [CW-1:0] p_h, input logic [CW-1:0] p_q);
    chk("exp_half", 32'(eh), 32'(h));
    chk("exp_quarter", 32'(eq), 32'(q));
    chk("pre_half", 32'(ph), 32'(p_h));
    chk("pre_quarter", 32'(pq), 32'(p_q));
  endtask

  task automatic chk_zero();
    chk("zero_locked", 32'(locked), 32'd0);
    chk_rates(8'd0, 8'd0, 8'd0, 8'd0);
    chk("zero_offset", 32'(ofs), 32'd0);
    chk("zero_mult", 32'(mult), 32'd0);
    chk("zero_lost", 32'(lost), 32'd0);
    chk("zero_viol", 32'(viol), 32'd0);
    chk("zero_clk_state", 32'(clk_state), 32'd0);
  endtask

  initial begin
    io = 1'b0; enable = 1'b0; rst_n = 1'b0; lead = 8'd2;
    cyc = 0; last_t = 0; vectors = 0; miscompares = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_zero();
    enable = 1'b1;
    last_t = cyc;

    // steady rate 10: first edge, then four intervals of 10
    edge_at(3);
    step(); chk("clk_state_rise", 32'(clk_state), 32'h6);
    step(); chk("clk_state_level", 32'(clk_state), 32'h4);
    for (int i = 0; i < 4; i++) edge_at(10);
    step(); chk("lock_early", 32'(locked), 32'd0);
    step(); chk("lock_on", 32'(locked), 32'd1);
    chk_rates(8'd8, 8'd4, 8'd7, 8'd2);
    chk("lock_offset", 32'(ofs), 32'd0);

    // drift within tolerance
    edge_at(11); expect_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 8'h01);
    edge_at(9);  expect_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 8'hFF);
    edge_at(10); expect_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 8'h00);
    step(); chk("drift_locked", 32'(locked), 32'd1);
    chk("drift_rate", 32'(eh), 32'd8);

    // like-bits at 2R..4R, including the tolerance edges
    edge_at(30); expect_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 8'h00);
    edge_at(21); expect_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 8'h01);
    edge_at(19); expect_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 8'hFF);
    edge_at(41); expect_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 8'h01);

    // rate change to 16: lose lock on first, relock after three more
    edge_at(16); expect_ev(cyc + 1, 1'b0, 1'b1, 1'b0, 8'h00);
    step(); chk("rate_hold", 32'(eh), 32'd8);
    for (int i = 0; i < 3; i++) edge_at(16);
    step(); step();
    chk("relock16", 32'(locked), 32'd1);
    chk_rates(8'd14, 8'd7, 8'd13, 8'd5);

    // back to rate 10, then let the line stall
    edge_at(10); expect_ev(cyc + 1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) edge_at(10);
    step(); step();
    chk("relock10", 32'(locked), 32'd1);
    chk("relock10_rate", 32'(eh), 32'd8);
    edge_at(10); expect_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_ev(last_t + 43, 1'b0, 1'b1, 1'b0, 8'h00);
    while (cyc < last_t + 45) step();
    chk("stall_unlocked", 32'(locked), 32'd0);

    // alternating 5/13 never locks: timeout after 32 acquire edges
    edge_at(50);
    for (int i = 0; i < 31; i++) edge_at((i % 2 == 0) ? 5 : 13);
    step(); chk("timeout_31", 32'(viol), 32'd0);
    edge_at(13);
    step(); chk("timeout_32", 32'(viol), 32'd1);
    edge_at(5); edge_at(13);
    step(); chk("timeout_sticky", 32'(viol), 32'd1);
    enable = 1'b0;
    step(); chk_zero();
    enable = 1'b1;
    step(); chk("timeout_cleared", 32'(viol), 32'd0);
    last_t = cyc;

    // glitch intervals of 1 never match
    edge_at(3);
    for (int i = 0; i < 6; i++) edge_at(1);
    step(); step(); chk("glitch_ones", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) edge_at(10);
    step(); step(); chk("glitch_no_lock", 32'(locked), 32'd0);
    edge_at(10);
    step(); chk("glitch_lock_early", 32'(locked), 32'd0);
    step(); chk("glitch_lock", 32'(locked), 32'd1);
    edge_at(11); expect_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 8'h01);
    step();

    // synchronous reset while locked
    rst_n = 1'b0;
    step(); chk_zero();
    rst_n = 1'b1;
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
